// File: rtl/matlib_pkg.sv
// Shared types and helpers for the iterative square-root block.
// Holds the FSM state encoding and the iteration-count function.
package matlib_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } usqrt_state_e;

    // One root bit per iteration; the radicand a<<frac is consumed two bits at a time.
    function automatic int usqrt_iters(input int width, input int frac);
        return (width + frac + 1) / 2;
    endfunction

endpackage

// File: rtl/usqrt_step.sv
// One non-restoring square-root iteration: shifts in the next radicand bit pair and
// adds or subtracts the trial term depending on the sign of the running remainder.
module usqrt_step #(
    parameter int N = 12
) (
    input  logic [N+1:0] rem_i,
    input  logic [N-1:0] root_i,
    input  logic [1:0]   pair_i,
    output logic [N+1:0] rem_o,
    output logic         bit_o
);

    logic [N+1:0] shifted;

    // Two's-complement wraparound in the shift is harmless: the final sum always fits N+2 bits.
    assign shifted = (rem_i << 2) | (N+2)'(pair_i);
    assign rem_o   = rem_i[N+1] ? shifted + {root_i, 2'b11}
                                : shifted - {root_i, 2'b01};
    assign bit_o   = ~rem_o[N+1];

endmodule

// File: rtl/usqrt_iter.sv
// Iterative unsigned fixed-point square root, one result bit per clock, valid/ready on both sides.
// Define USQRT_ROUND_EN for round-to-nearest (one extra cycle); default build truncates.
module usqrt_iter
    import matlib_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f
);

    localparam int N  = usqrt_iters(WIDTH, FRAC);
    localparam int CW = $clog2(N + 1);

    usqrt_state_e   state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] rad_q, rad_d;
    logic [N+1:0]   rem_q, rem_d;
    logic [N-1:0]   root_q, root_d;
    logic [WIDTH-1:0] f_q, f_d;

    logic [N+1:0]   step_rem;
    logic           step_bit;
    logic [N-1:0]   step_root;

    usqrt_step #(.N(N)) u_step (
        .rem_i  (rem_q),
        .root_i (root_q),
        .pair_i (rad_q[2*N-1 -: 2]),
        .rem_o  (step_rem),
        .bit_o  (step_bit)
    );

    assign step_root = (root_q << 1) | N'(step_bit);

`ifdef USQRT_ROUND_EN
    logic [N+1:0]   rem_true;
    logic           round_up;
    logic [WIDTH:0] root_inc;
    logic [WIDTH-1:0] round_f;

    // A negative final remainder still owes the last trial term back.
    assign rem_true = rem_q[N+1] ? rem_q + (N+2)'({root_q, 1'b1}) : rem_q;
    assign round_up = rem_true > (N+2)'(root_q);
    assign root_inc = (WIDTH+1)'(root_q) + (WIDTH+1)'(round_up);
    assign round_f  = root_inc[WIDTH] ? '1 : root_inc[WIDTH-1:0];
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        rad_d     = rad_q;
        rem_d     = rem_q;
        root_d    = root_q;
        f_d       = f_q;
        in_ready  = (state_q == IDLE) && !reset;
        out_valid = (state_q == DONE);

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    rad_d   = (2*N)'(a) << FRAC;
                    rem_d   = '0;
                    root_d  = '0;
                end
            end
            CALC: begin
                cnt_d = cnt_q + 1'b1;
`ifdef USQRT_ROUND_EN
                if (cnt_q == CW'(N)) begin
                    state_d = DONE;
                    f_d     = round_f;
                end else begin
                    rad_d  = rad_q << 2;
                    rem_d  = step_rem;
                    root_d = step_root;
                end
`else
                rad_d  = rad_q << 2;
                rem_d  = step_rem;
                root_d = step_root;
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                    f_d     = WIDTH'(step_root);
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; every register has a defined reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rad_q   <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            f_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rad_q   <= rad_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            f_q     <= f_d;
        end
    end

    assign f = f_q;

endmodule

// File: tb/tb_usqrt_iter.sv
// Directed and randomized checks of usqrt_iter (WIDTH=16, FRAC=8, N=12).
// Follows USQRT_ROUND_EN for expected values and latency.
module tb_usqrt_iter;

`ifdef USQRT_ROUND_EN
    localparam int LAT = 13;
`else
    localparam int LAT = 12;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] f;

    int checks = 0;
    int errors = 0;

    usqrt_iter #(.WIDTH(16), .FRAC(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Floor square root by linear search, rounded like the design when enabled.
    function automatic logic [15:0] model(input logic [15:0] av);
        longint x = longint'(av) << 8;
        longint q = 0;
        while ((q + 1) * (q + 1) <= x) q++;
`ifdef USQRT_ROUND_EN
        if (x - q * q > q) q++;
        if (q > 65535) q = 65535;
`endif
        return 16'(q);
    endfunction

    // Waits for in_ready, presents one operand for exactly one accepting edge.
    task automatic start(input logic [15:0] v);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("start_timeout", 32'(in_ready), 1);
        in_valid = 1'b1;
        a        = v;
        @(negedge clk);
        in_valid = 1'b0;
        a        = 16'hDEAD;
    endtask

    // Counts edges after the accept until out_valid is seen.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_one(input string tag, input logic [15:0] v, input logic [15:0] exp);
        int lat;
        start(v);
        wait_done(lat);
        check({tag, "_lat"}, 32'(lat), 32'(LAT));
        check({tag, "_f"}, 32'(f), 32'(exp));
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int delivered;
        int guard;
        logic got;
        logic [15:0] av;
        logic [15:0] ev;

        reset     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_f", 32'(f), 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 1);

        run_one("four", 16'h0400, 16'h0200);
        run_one("two", 16'h0200, 16'h016A);
`ifdef USQRT_ROUND_EN
        run_one("max", 16'hFFFF, 16'h1000);
`else
        run_one("max", 16'hFFFF, 16'h0FFF);
`endif
        run_one("zero", 16'h0000, 16'h0000);
        run_one("nine", 16'h0900, 16'h0300);

        // Backpressure: result must hold, and a request during DONE must be dropped.
        out_ready = 1'b0;
        start(16'h0400);
        wait_done(lat);
        check("bp_lat", 32'(lat), 32'(LAT));
        check("bp_f", 32'(f), 32'h0200);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a        = 16'h0100;
            @(negedge clk);
            check("bp_hold_valid", 32'(out_valid), 1);
            check("bp_hold_f", 32'(f), 32'h0200);
            check("bp_hold_in_ready", 32'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(out_valid), 0);
        check("bp_release_f", 32'(f), 32'h0200);
        check("bp_release_in_ready", 32'(in_ready), 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) check("bp_no_queue", 32'(out_valid), 0);
        end
        check("bp_idle_after", 32'(out_valid), 0);

        // Reset during the sixth iteration abandons the operation.
        start(16'h0400);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_f", 32'(f), 0);
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_in_ready", 32'(in_ready), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) check("midrst_no_output", 32'(out_valid), 0);
        end
        check("midrst_f_after", 32'(f), 0);
        run_one("after_rst", 16'h0900, 16'h0300);

        // Random operands with random handshake timing against the reference model.
        delivered = 0;
        for (int n = 0; n < 1000; n++) begin
            av = 16'($urandom_range(0, 65535));
            ev = model(av);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            start(av);
            got   = 1'b0;
            guard = 0;
            while (!got && guard < 200) begin
                out_ready = 1'($urandom_range(0, 1));
                #1;
                if (out_valid && out_ready) begin
                    check("rand_f", 32'(f), 32'(ev));
                    got = 1'b1;
                    delivered++;
                end
                @(negedge clk);
                guard++;
            end
            if (!got) check("rand_timeout", 32'(got), 1);
            check("rand_no_dup", 32'(out_valid), 0);
        end
        out_ready = 1'b1;
        check("rand_delivered", 32'(delivered), 1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
